// File: rtl/monitor_enlace_serie.sv
// Serial link for the infant monitor: framed N_CH-bit transmitter, mid-bit sampling receiver, link watchdog.
// Optional even parity bit on both directions when MONITOR_PARIDAD_EN is defined.
module monitor_enlace_serie #(
  parameter int N_CH        = 8,
  parameter int CLK_HZ      = 100000000,
  parameter int BAUD        = 1200,
  parameter int CHANGE_TX   = 1,
  parameter int TIMEOUT_CYC = 50000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] tx_data,
  input  logic            tx_start,
  output logic            tx_busy,
  output logic            txd,
  input  logic            rxd,
  output logic [N_CH-1:0] rx_data,
  output logic            rx_valid,
  output logic            rx_err,
  output logic            link_ok
);

`ifdef MONITOR_PARIDAD_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  localparam int DIV = CLK_HZ / BAUD;
  localparam int FB  = N_CH + 2 + PB;
  localparam int SW  = FB - 1;
  localparam int CW  = $clog2(DIV + 1);
  localparam int BW  = $clog2(FB + 1);
  localparam int IW  = $clog2(N_CH + 1);
  localparam int WDW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [CW-1:0]  DIV_C  = CW'(DIV);
  localparam logic [CW-1:0]  ONE_C  = CW'(1);
  // The IDLE detection cycle already counts towards the half bit.
  localparam logic [CW-1:0]  HALF_C = CW'(DIV / 2 - 1);
  localparam logic [BW-1:0]  LAST_B = BW'(FB - 1);
  localparam logic [IW-1:0]  LAST_I = IW'(N_CH - 1);
  localparam logic [WDW-1:0] TO_C   = WDW'(TIMEOUT_CYC);

  // ---------------------------------------------------------------- transmitter
  typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;

  tx_state_t       tx_state_reg, tx_state_next;
  logic [SW-1:0]   tx_shift_reg, tx_shift_next;
  logic [CW-1:0]   tx_cyc_reg, tx_cyc_next;
  logic [BW-1:0]   tx_bit_reg, tx_bit_next;
  logic            txd_reg, txd_next;
  logic            tx_busy_reg, tx_busy_next;
  logic [N_CH-1:0] last_sent_reg, last_sent_next;
  logic [SW-1:0]   tx_frame;
  logic            launch;

  always_comb begin
    // Everything after the start bit, sent LSB first; start bit goes straight to txd.
`ifdef MONITOR_PARIDAD_EN
    tx_frame = {1'b1, ^tx_data, tx_data};
`else
    tx_frame = {1'b1, tx_data};
`endif
    launch = tx_start || ((CHANGE_TX != 0) && (tx_data != last_sent_reg));

    tx_state_next  = tx_state_reg;
    tx_shift_next  = tx_shift_reg;
    tx_cyc_next    = tx_cyc_reg;
    tx_bit_next    = tx_bit_reg;
    txd_next       = txd_reg;
    tx_busy_next   = tx_busy_reg;
    last_sent_next = last_sent_reg;

    case (tx_state_reg)
      TX_IDLE: begin
        if (launch) begin
          tx_state_next  = TX_SEND;
          tx_shift_next  = tx_frame;
          last_sent_next = tx_data;
          tx_busy_next   = 1'b1;
          txd_next       = 1'b0;
          tx_cyc_next    = '0;
          tx_bit_next    = '0;
        end
      end
      TX_SEND: begin
        if (tx_cyc_reg == DIV_C - ONE_C) begin
          tx_cyc_next = '0;
          if (tx_bit_reg == LAST_B) begin
            tx_state_next = TX_IDLE;
            tx_busy_next  = 1'b0;
            txd_next      = 1'b1;
          end else begin
            tx_bit_next   = tx_bit_reg + BW'(1);
            txd_next      = tx_shift_reg[0];
            tx_shift_next = {1'b1, tx_shift_reg[SW-1:1]};
          end
        end else begin
          tx_cyc_next = tx_cyc_reg + ONE_C;
        end
      end
      default: tx_state_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_reg  <= TX_IDLE;
      tx_shift_reg  <= '1;
      tx_cyc_reg    <= '0;
      tx_bit_reg    <= '0;
      txd_reg       <= 1'b1;
      tx_busy_reg   <= 1'b0;
      last_sent_reg <= '0;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_shift_reg  <= tx_shift_next;
      tx_cyc_reg    <= tx_cyc_next;
      tx_bit_reg    <= tx_bit_next;
      txd_reg       <= txd_next;
      tx_busy_reg   <= tx_busy_next;
      last_sent_reg <= last_sent_next;
    end
  end

  assign txd     = txd_reg;
  assign tx_busy = tx_busy_reg;

  // ---------------------------------------------------------------- receiver
  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef MONITOR_PARIDAD_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  rx_state_t       rx_state_reg, rx_state_next;
  logic            rx_meta_reg, rxs_reg;
  logic [CW-1:0]   rx_cnt_reg, rx_cnt_next;
  logic [IW-1:0]   rx_idx_reg, rx_idx_next;
  logic [N_CH-1:0] rx_shift_reg, rx_shift_next;
  logic [N_CH-1:0] rx_data_reg, rx_data_next;
  logic            rx_valid_reg, rx_valid_next;
  logic            rx_err_reg, rx_err_next;
  logic            rx_tick;
  logic            par_ok;
`ifdef MONITOR_PARIDAD_EN
  logic            rx_par_reg, rx_par_next;
  assign par_ok = (rx_par_reg == ^rx_shift_reg);
`else
  assign par_ok = 1'b1;
`endif

  assign rx_tick = (rx_cnt_reg == ONE_C);

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = (rx_cnt_reg != '0) ? rx_cnt_reg - ONE_C : rx_cnt_reg;
    rx_idx_next   = rx_idx_reg;
    rx_shift_next = rx_shift_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_err_next   = 1'b0;
`ifdef MONITOR_PARIDAD_EN
    rx_par_next   = rx_par_reg;
`endif

    case (rx_state_reg)
      RX_IDLE: begin
        if (!rxs_reg) begin
          rx_state_next = RX_START;
          rx_cnt_next   = HALF_C;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          if (!rxs_reg) begin
            rx_state_next = RX_DATA;
            rx_cnt_next   = DIV_C;
            rx_idx_next   = '0;
          end else begin
            rx_state_next = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_shift_next = (rx_shift_reg >> 1) | (N_CH'(rxs_reg) << (N_CH - 1));
          rx_cnt_next   = DIV_C;
          if (rx_idx_reg == LAST_I) begin
`ifdef MONITOR_PARIDAD_EN
            rx_state_next = RX_PARITY;
`else
            rx_state_next = RX_STOP;
`endif
          end else begin
            rx_idx_next = rx_idx_reg + IW'(1);
          end
        end
      end
`ifdef MONITOR_PARIDAD_EN
      RX_PARITY: begin
        if (rx_tick) begin
          rx_par_next   = rxs_reg;
          rx_cnt_next   = DIV_C;
          rx_state_next = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (rx_tick) begin
          if (rxs_reg && par_ok) begin
            rx_data_next  = rx_shift_reg;
            rx_valid_next = 1'b1;
            rx_state_next = RX_IDLE;
          end else begin
            rx_err_next   = 1'b1;
            rx_state_next = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        // A line held low must go idle before a new start bit can be trusted.
        if (rxs_reg) rx_state_next = RX_IDLE;
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_err_reg   <= 1'b0;
`ifdef MONITOR_PARIDAD_EN
      rx_par_reg   <= 1'b0;
`endif
    end else begin
      rx_meta_reg  <= rxd;
      rxs_reg      <= rx_meta_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_idx_reg   <= rx_idx_next;
      rx_shift_reg <= rx_shift_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_err_reg   <= rx_err_next;
`ifdef MONITOR_PARIDAD_EN
      rx_par_reg   <= rx_par_next;
`endif
    end
  end

  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign rx_err   = rx_err_reg;

  // ---------------------------------------------------------------- watchdog
  logic [WDW-1:0] wd_cnt_reg, wd_cnt_next;
  logic           link_ok_reg, link_ok_next;

  always_comb begin
    if (rx_valid_next)
      wd_cnt_next = '0;
    else if (wd_cnt_reg != TO_C)
      wd_cnt_next = wd_cnt_reg + WDW'(1);
    else
      wd_cnt_next = wd_cnt_reg;
    // Rises the cycle after rx_valid; falls once TIMEOUT_CYC cycles have elapsed since it.
    link_ok_next = rx_valid_reg || (link_ok_reg && (wd_cnt_next != TO_C));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_reg  <= '0;
      link_ok_reg <= 1'b0;
    end else begin
      wd_cnt_reg  <= wd_cnt_next;
      link_ok_reg <= link_ok_next;
    end
  end

  assign link_ok = link_ok_reg;

endmodule

// File: tb/tb_monitor_enlace_serie.sv
// Directed bench for monitor_enlace_serie: TX framing, auto-send, loopback, framing error, glitch, watchdog, reset.
module tb_monitor_enlace_serie;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       txd;
  logic       rxd;
  logic       rxd_drv;
  logic       loop_en;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic       link_ok;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // monitor state (written only by the monitor process)
  int         busy_rises     = 0;
  int         rx_valid_cnt   = 0;
  int         rx_err_cnt     = 0;
  int         both_cnt       = 0;
  int         last_valid_cyc = 0;
  int         link_rise_cyc  = 0;
  int         link_fall_cyc  = 0;
  logic       busy_q         = 1'b0;
  logic       link_q         = 1'b0;
  logic [7:0] obs_mem [0:63];

  logic [7:0] exp_q [$];
  int         rd_idx = 0;

  assign rxd = loop_en ? txd : rxd_drv;

  always #5 clk = ~clk;

  monitor_enlace_serie #(
    .N_CH(8), .CLK_HZ(12000), .BAUD(1200), .CHANGE_TX(1), .TIMEOUT_CYC(300)
  ) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
    .tx_busy(tx_busy), .txd(txd), .rxd(rxd), .rx_data(rx_data),
    .rx_valid(rx_valid), .rx_err(rx_err), .link_ok(link_ok)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    busy_q <= tx_busy;
    link_q <= link_ok;
    if (tx_busy && !busy_q) busy_rises <= busy_rises + 1;
    if (link_ok && !link_q) link_rise_cyc <= cyc;
    if (!link_ok && link_q) link_fall_cyc <= cyc;
    if (rx_err) rx_err_cnt <= rx_err_cnt + 1;
    if (rx_valid && rx_err) both_cnt <= both_cnt + 1;
    if (rx_valid) begin
      if (rx_valid_cnt < 64) obs_mem[rx_valid_cnt] <= rx_data;
      rx_valid_cnt   <= rx_valid_cnt + 1;
      last_valid_cyc <= cyc;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, data, 1'b0};
    for (int b = 0; b < 10; b++) begin
      rxd_drv = fr[b];
      tick(10);
    end
  endtask

  task automatic drain();
    logic [7:0] e;
    while (rd_idx < rx_valid_cnt) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rx_valid", 32'(rd_idx), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("rx_data_%0d", rd_idx), 32'(obs_mem[rd_idx]), 32'(e));
      end
      rd_idx++;
    end
  endtask

  initial begin
    logic [9:0] fr;
    int hits, busy_cnt, r0, nv, ne, launch_cyc, first_valid;

    rst = 1'b1; tx_data = 8'h00; tx_start = 1'b0; rxd_drv = 1'b1; loop_en = 1'b0;
    tick(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_tx_busy", 32'(tx_busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_err", 32'(rx_err), 32'd0);
    check("rst_link_ok", 32'(link_ok), 32'd0);
    rst = 1'b0;
    tick(5);
    check("idle_no_autosend", 32'(tx_busy), 32'd0);

    // TX frame of 0xA5
    tx_data = 8'hA5; tx_start = 1'b1;
    tick(1);
    tx_start = 1'b0;
    fr = {1'b1, 8'hA5, 1'b0};
    busy_cnt = 0;
    for (int b = 0; b < 10; b++) begin
      hits = 0;
      for (int j = 0; j < 10; j++) begin
        if (txd === fr[b]) hits++;
        if (tx_busy === 1'b1) busy_cnt++;
        tick(1);
      end
      check($sformatf("txd_bit%0d_cycles", b), 32'(hits), 32'd10);
    end
    check("tx_busy_cycles", 32'(busy_cnt), 32'd100);
    check("txd_idle_after", 32'(txd), 32'd1);
    check("tx_busy_low_after", 32'(tx_busy), 32'd0);

    // auto-send on change 0x00 -> 0x03
    rst = 1'b1; tx_data = 8'h00;
    tick(2);
    rst = 1'b0;
    tick(3);
    r0 = busy_rises;
    tx_data = 8'h03;
    tick(300);
    check("autosend_frames", 32'(busy_rises - r0), 32'd1);
    check("autosend_idle", 32'(tx_busy), 32'd0);

    // loopback 0x3C then 0xC3
    loop_en = 1'b1;
    tick(2);
    nv = rx_valid_cnt;
    exp_q.push_back(8'h3C);
    tx_data = 8'h3C;
    launch_cyc = cyc + 1;
    tick(1);
    for (int i = 0; i < 200 && rx_valid_cnt == nv; i++) tick(1);
    check("loop_first_valid", 32'(rx_valid_cnt - nv), 32'd1);
    first_valid = last_valid_cyc;
    check("loop_latency", 32'(first_valid - launch_cyc), 32'd97);
    for (int i = 0; i < 200 && tx_busy; i++) tick(1);
    exp_q.push_back(8'hC3);
    tx_data = 8'hC3;
    tick(1);
    for (int i = 0; i < 250 && rx_valid_cnt < nv + 2; i++) tick(1);
    check("loop_valid_count", 32'(rx_valid_cnt - nv), 32'd2);
    drain();
    check("link_rise_cycle", 32'(link_rise_cyc - first_valid), 32'd1);
    check("link_ok_after_loop", 32'(link_ok), 32'd1);
    check("rx_data_last_loop", 32'(rx_data), 32'hC3);
    tick(10);
    loop_en = 1'b0;

    // frame with a 0 stop bit, line held low, then a valid frame
    nv = rx_valid_cnt; ne = rx_err_cnt;
    send_frame(8'h55, 1'b0);
    rxd_drv = 1'b0;
    tick(30);
    check("stop_err_pulses", 32'(rx_err_cnt - ne), 32'd1);
    check("stop_err_no_valid", 32'(rx_valid_cnt - nv), 32'd0);
    check("stop_err_data_kept", 32'(rx_data), 32'hC3);
    rxd_drv = 1'b1;
    tick(20);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    tick(20);
    check("recover_valid", 32'(rx_valid_cnt - nv), 32'd1);
    check("recover_err_total", 32'(rx_err_cnt - ne), 32'd1);
    drain();

    // 3-cycle low glitch
    nv = rx_valid_cnt; ne = rx_err_cnt;
    rxd_drv = 1'b0;
    tick(3);
    rxd_drv = 1'b1;
    tick(150);
    check("glitch_no_valid", 32'(rx_valid_cnt - nv), 32'd0);
    check("glitch_no_err", 32'(rx_err_cnt - ne), 32'd0);
    check("link_ok_before_timeout", 32'(link_ok), 32'd1);

    // watchdog expiry
    for (int i = 0; i < 400 && link_ok; i++) tick(1);
    check("link_ok_dropped", 32'(link_ok), 32'd0);
    check("watchdog_cycles", 32'(link_fall_cyc - last_valid_cyc), 32'd300);

    // reset in the middle of a TX frame
    tx_data = 8'h77;
    tick(35);
    check("midframe_busy", 32'(tx_busy), 32'd1);
    rst = 1'b1; tx_data = 8'h00;
    tick(1);
    check("midrst_txd", 32'(txd), 32'd1);
    check("midrst_tx_busy", 32'(tx_busy), 32'd0);
    check("midrst_rx_data", 32'(rx_data), 32'd0);
    rst = 1'b0;
    tick(20);
    check("post_rst_idle", 32'(tx_busy), 32'd0);

    drain();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("valid_err_exclusive", 32'(both_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/monitor_enlace_serie.md
# monitor_enlace_serie

Parametrised serial link for the infant monitor. It replaces the fixed 8-bit parallel-serial and serial-parallel converters with one block that:
- frames `N_CH` alarm/sensor bits, LSB first, with start and stop bits;
- generates its own baud timing from the board clock;
- receives remote frames with mid-bit sampling, stop-bit checking and glitch rejection;
- raises a link watchdog when remote frames stop arriving.

It sits between the alert decoders and the MAX232 pins (P9 transmit, receive pin).

## Interface
Parameters:
- `N_CH`, 8, data bits per frame (1–16).
- `CLK_HZ`, 100000000, `clk` frequency in Hz.
- `BAUD`, 1200, bit rate.
- `CHANGE_TX`, 1, 1 = launch a frame automatically when `tx_data` differs from the last transmitted word.
- `TIMEOUT_CYC`, 50000000, `clk` cycles without a valid frame before `link_ok` drops.

Ports:
- `clk`  in  1  board clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  N_CH  local alarm/sensor word.
- `tx_start`  in  1  one-cycle request to send `tx_data`.
- `tx_busy`  out  1  transmitter active.
- `txd`  out  1  serial output; idles high.
- `rxd`  in  1  asynchronous serial input.
- `rx_data`  out  N_CH  last valid received word.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `rx_err`  out  1  one-cycle pulse on a framing or parity error.
- `link_ok`  out  1  a valid frame arrived within the last `TIMEOUT_CYC` cycles.

## Operation
- Bit period is `DIV = CLK_HZ/BAUD` clock cycles, truncated. `DIV >= 4` is required.
- Frame: start bit (0), `N_CH` data bits LSB first, optional parity bit, stop bit (1). `FB` is the total bit count: `N_CH+2`, or `N_CH+3` with parity.

Transmitter FSM: IDLE → SEND → IDLE.
- In IDLE, a launch occurs on `tx_start`, or when `CHANGE_TX=1` and `tx_data` differs from `last_sent`.
- On launch: shift register ← frame built from `tx_data`; `last_sent` ← `tx_data`; `tx_busy` ← 1.
- `tx_start` while busy is ignored and not queued. A change of `tx_data` while busy is picked up in IDLE after the frame completes.

Receiver:
- `rxd` passes through a 2-flop synchroniser (`rxs`).
- FSM states: IDLE, START, DATA, STOP, BREAK.
  - IDLE: `rxs`=0 → START; load counter with `DIV/2`.
  - START: on counter expiry, `rxs`=0 → DATA (counter ← `DIV`); `rxs`=1 → IDLE (glitch, no `rx_err`).
  - DATA: sample `rxs` every `DIV` cycles into bit `i`, LSB first. After `N_CH` samples → STOP, or → PARITY with parity compiled in.
  - STOP: sample after `DIV`.
    - 1 and parity OK → `rx_data` ← assembled word, `rx_valid` pulse, → IDLE.
    - Otherwise → `rx_err` pulse, `rx_data` unchanged, → BREAK.
  - BREAK: wait for `rxs`=1, then → IDLE.
- Watchdog:
  - The counter clears on every `rx_valid` and otherwise increments, saturating at `TIMEOUT_CYC`.
  - `link_ok` = 1 from the cycle after `rx_valid` until the counter reaches `TIMEOUT_CYC`.

## Timing
- Reset values: `txd`=1, `tx_busy`=0, `rx_data`=0, `rx_valid`=0, `rx_err`=0, `link_ok`=0. Both FSMs go to IDLE; `last_sent` ← 0, so no auto-send fires while `tx_data`=0.
- `rst` mid-frame aborts immediately. `txd` returns high on the next edge and no partial frame is completed.
- TX latency: launch at edge E. `txd`=0 and `tx_busy`=1 from E+1. Each bit lasts exactly `DIV` cycles. `tx_busy` falls at E+1+`FB*DIV`, and the next launch can occur in that same cycle.
- RX latency: `rx_valid` is asserted 2 (sync) + `DIV/2` + (`FB`−1)·`DIV` cycles after the falling edge of the start bit on `rxd`.
- `rx_valid` and `rx_err` are never asserted together.
- A start bit arriving in the cycle the receiver returns to IDLE is accepted (back-to-back frames).
- TX and RX are independent. Loopback (`txd`→`rxd`) is legal.

## Configuration
- `MONITOR_PARIDAD_EN` defined:
  - Even-parity bit inserted after the data bits on TX.
  - Checked on RX; a mismatch gives `rx_err` and → BREAK, even when the stop bit is valid.
  - `FB = N_CH+3`.
- `MONITOR_PARIDAD_EN` undefined: no parity bit, `FB = N_CH+2`, and only the stop bit is checked.

## Test plan
All scenarios use `CLK_HZ`=12000, `BAUD`=1200 (`DIV`=10), `N_CH`=8, no parity, `TIMEOUT_CYC`=300.
- `tx_start` with `tx_data`=0xA5:
  - `txd` = 0,1,0,1,0,0,1,0,1,1, each level held 10 cycles.
  - `tx_busy` high for exactly 100 cycles.
- `CHANGE_TX`=1, `tx_data` 0x00→0x03: exactly one frame is sent with no `tx_start`. Holding 0x03 sends no further frames.
- Loopback of 0x3C, then 0xC3 back-to-back:
  - two `rx_valid` pulses, the first exactly 97 cycles after the start-bit edge;
  - `rx_data`=0x3C, then 0xC3;
  - `link_ok` rises after the first frame.
- Frame driven with a 0 stop bit: `rx_err` pulses once, `rx_data` unchanged, no `rx_valid`. A valid frame is accepted only after `rxd` returns high.
- 3-cycle low glitch on `rxd`: no `rx_valid`, no `rx_err`.
- Watchdog: `link_ok` falls 300 cycles after the last `rx_valid`. Asserting `rst` mid-TX-frame sets `txd`=1 and `tx_busy`=0 at the next edge.
